fp32_to_bf16: RTL
=================

Name: fp32_to_bf16

Overview:
- Streaming FP32→BF16 down-converter with IEEE-754 rounding and exception flags.
- Feeds BF16 operands to the accelerator datapath from FP32 sources. It is the return path of the BF16→FP32 widening converter.
- 2-stage pipeline with valid/ready handshakes on both sides and full backpressure.
- Provides per-result flags and an accumulated sticky flag register.

Parameters:
- TAG_W, 4: width of opaque tag carried alongside each operand, in order.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input operand valid
- in_ready  out  1  converter can accept input this cycle
- operand_a  in  32  FP32 input
- rnd_mode  in  3  rounding mode, sampled with operand: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5-7 treated as RNE
- in_tag  in  TAG_W  tag captured with operand
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  16  BF16 result
- out_tag  out  TAG_W  tag of result
- invalid, overflow, underflow, inexact  out  1 each  per-result flags, valid with out_valid
- fflags  out  4  sticky {invalid, overflow, underflow, inexact}
- fflags_clear  in  1  clear sticky flags

Behaviour:
- Reset: clocked on clk, synchronous, active-high.
  - Clears both stage valids, so out_valid=0.
  - result, out_tag and the per-result flags are 0; fflags=0.
  - in_ready=1 the cycle after reset deasserts.
  - Reset mid-stream drops all in-flight operands; no output handshake occurs for them.
- Handshake:
  - A transfer happens when valid&&ready.
  - Once out_valid is asserted, result, tag and flags stay stable until accepted.
  - Stage k loads when it is empty or its contents leave this cycle.
  - in_ready = !s1_valid || (s1 moves to s2).
  - Sustained throughput is 1/cycle. Latency from input handshake to out_valid is 2 cycles.
  - No combinational path in_valid→out_valid. The only combinational path is out_ready→in_ready.
- Stage 1 (classify and round decision):
  - sign = operand_a[31]; kept = operand_a[30:16]; lsb = bit16; g = bit15; s = |bits[14:0].
  - Round-up decision by mode:
    - RNE: g&&(s||lsb)
    - RTZ: 0
    - RDN: sign&&(g||s)
    - RUP: !sign&&(g||s)
    - RMM: g
  - inexact_pre = g||s.
- Stage 2 (pack):
  - mag = kept + roundup (15-bit add). The carry into the exponent is the intended behaviour.
  - Finite input whose mag exponent becomes 0xFF: result = {sign,0x7F80}, overflow=1, inexact=1.
  - Infinity input (exp FF, man 0): passed through with sign; no flags.
  - NaN input: result 0x7FC0 (canonical, sign 0). invalid=1 only for sNaN (man≠0, bit22=0). qNaN sets no flags. inexact=0 for any NaN.
  - Zero input: signed zero; no flags.
  - Subnormal or underflow: underflow = (operand exp==0) && inexact. Tininess is detected before rounding.
- Sticky flags:
  - On each output handshake, fflags |= per-result flags.
  - fflags_clear in the same cycle as a handshake: old bits cleared, the new result's flags retained.
  - Clear alone: fflags=0 next cycle.

Decomposition:
- Shared package holds:
  - rnd_mode_e enum (RNE/RTZ/RDN/RUP/RMM)
  - BF16/FP32 field-width constants
  - BF16_QNAN=16'h7FC0, BF16_INF=15'h7F80
  - fflags struct
- One natural sub-module, bf16_round_decide: combinational round-up/inexact decision from sign, lsb, g, s and mode. It is reusable by later BF16 arithmetic units.

Test Plan:
- 0x3F800000 RNE, out_ready=1 → 0x3F80, no flags, out_valid exactly 2 cycles after accept.
- Ties at RNE:
  - 0x3F808000 → 0x3F80, inexact.
  - 0x3F818000 → 0x3F82, inexact.
- Directed modes:
  - 0x3F800001 RUP → 0x3F81, inexact.
  - 0xBF800001 RDN → 0xBF81, inexact.
  - 0xBF800001 RTZ → 0xBF80, inexact.
- Overflow: 0x7F7FFFFF RNE → 0x7F80, overflow+inexact. Same input RTZ → 0x7F7F, inexact only.
- NaN and subnormal:
  - 0x7F800001 → 0x7FC0, invalid=1.
  - 0xFFC00000 → 0x7FC0, no flags.
  - 0x00008001 RNE → 0x0001, underflow+inexact.
- Backpressure and reset:
  - Hold out_ready=0 while offering tags 1,2,3 → in_ready drops after 2 accepts; on release, results arrive in tag order 1,2,3 with fflags equal to the OR of their flags.
  - Assert reset with 2 in flight → out_valid=0 next cycle, fflags=0.

Source files
------------

// File: rtl/fp32_to_bf16_pkg.sv
// Shared definitions for the FP32 -> BF16 down-converter and related BF16 units.
//   rnd_mode_e : rounding mode encoding (codes 5-7 behave as RNE)
//   FP32_* / BF16_* : field widths of the two formats
//   BF16_QNAN  : canonical quiet NaN produced for any NaN input
//   BF16_INF   : BF16 infinity magnitude (sign supplied separately)
//   fflags_t   : exception flag bundle {invalid, overflow, underflow, inexact}
package fp32_to_bf16_pkg;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rnd_mode_e;

    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int BF16_EXP_W = 8;
    localparam int BF16_MAN_W = 7;

    // Number of FP32 mantissa bits discarded when narrowing to BF16.
    localparam int DROP_W = FP32_MAN_W - BF16_MAN_W;

    localparam logic [15:0] BF16_QNAN = 16'h7FC0;
    localparam logic [14:0] BF16_INF  = 15'h7F80;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fflags_t;

endpackage

// File: rtl/fp32_to_bf16_round_decide.sv
// bf16_round_decide: combinational round-up / inexact decision for BF16 results.
//   sign     : sign of the value being rounded
//   lsb      : least significant kept mantissa bit
//   guard    : first discarded bit
//   sticky   : OR of all remaining discarded bits
//   rnd_mode : rounding mode (rnd_mode_e encoding; unknown codes act as RNE)
//   round_up : add one ulp to the truncated magnitude
//   inexact  : discarded bits were non-zero
module bf16_round_decide
    import fp32_to_bf16_pkg::*;
(
    input  logic       sign,
    input  logic       lsb,
    input  logic       guard,
    input  logic       sticky,
    input  logic [2:0] rnd_mode,
    output logic       round_up,
    output logic       inexact
);

    always_comb begin
        inexact  = guard | sticky;
        round_up = 1'b0;
        case (rnd_mode)
            RTZ:     round_up = 1'b0;
            RDN:     round_up = sign & (guard | sticky);
            RUP:     round_up = ~sign & (guard | sticky);
            RMM:     round_up = guard;
            default: round_up = guard & (sticky | lsb);   // RNE, also codes 5-7
        endcase
    end

endmodule

// File: rtl/fp32_to_bf16.sv
// fp32_to_bf16: streaming FP32 -> BF16 converter, two register stages.
//   clk, reset              : clock, synchronous active-high reset
//   in_valid/in_ready       : input handshake; operand_a, rnd_mode, in_tag travel together
//   out_valid/out_ready     : output handshake; result, out_tag and per-result flags
//   invalid/overflow/underflow/inexact : flags of the presented result
//   fflags                  : sticky {invalid, overflow, underflow, inexact}
//   fflags_clear            : clears sticky flags (flags of a same-cycle result survive)
// Stage 1 registers the classification and the rounding decision; stage 2 registers
// the packed result. The only combinational path is out_ready -> in_ready.
module fp32_to_bf16
    import fp32_to_bf16_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      operand_a,
    input  logic [2:0]       rnd_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      result,
    output logic [TAG_W-1:0] out_tag,
    output logic             invalid,
    output logic             overflow,
    output logic             underflow,
    output logic             inexact,
    output logic [3:0]       fflags,
    input  logic             fflags_clear
);

    // ---------------- stage 1: classify + round decision ----------------
    logic [FP32_EXP_W-1:0] in_exp;
    logic [FP32_MAN_W-1:0] in_man;
    logic                  in_exp_ones;
    logic                  in_exp_zero;
    logic                  in_man_zero;
    logic                  dec_round_up;
    logic                  dec_inexact;

    assign in_exp      = operand_a[FP32_MAN_W +: FP32_EXP_W];
    assign in_man      = operand_a[FP32_MAN_W-1:0];
    assign in_exp_ones = &in_exp;
    assign in_exp_zero = ~|in_exp;
    assign in_man_zero = ~|in_man;

    bf16_round_decide u_round_decide (
        .sign     (operand_a[31]),
        .lsb      (operand_a[DROP_W]),
        .guard    (operand_a[DROP_W-1]),
        .sticky   (|operand_a[DROP_W-2:0]),
        .rnd_mode (rnd_mode),
        .round_up (dec_round_up),
        .inexact  (dec_inexact)
    );

    logic             s1_valid_reg;
    logic             s1_sign_reg;
    logic [14:0]      s1_kept_reg;
    logic             s1_round_up_reg;
    logic             s1_inexact_reg;
    logic             s1_is_nan_reg;
    logic             s1_is_snan_reg;
    logic             s1_is_inf_reg;
    logic             s1_is_zero_reg;
    logic             s1_exp_zero_reg;
    logic [TAG_W-1:0] s1_tag_reg;

    logic s2_valid_reg;
    logic s2_load;
    logic s1_load;
    logic out_hs;

    assign out_hs   = s2_valid_reg & out_ready;
    // Stage 2 takes stage 1's contents when it is empty or its result leaves now.
    assign s2_load  = s1_valid_reg & (~s2_valid_reg | out_ready);
    assign in_ready = ~s1_valid_reg | s2_load;
    assign s1_load  = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg    <= 1'b0;
            s1_sign_reg     <= 1'b0;
            s1_kept_reg     <= '0;
            s1_round_up_reg <= 1'b0;
            s1_inexact_reg  <= 1'b0;
            s1_is_nan_reg   <= 1'b0;
            s1_is_snan_reg  <= 1'b0;
            s1_is_inf_reg   <= 1'b0;
            s1_is_zero_reg  <= 1'b0;
            s1_exp_zero_reg <= 1'b0;
            s1_tag_reg      <= '0;
        end else begin
            if (s1_load) begin
                s1_valid_reg    <= 1'b1;
                s1_sign_reg     <= operand_a[31];
                s1_kept_reg     <= operand_a[30:DROP_W];
                s1_round_up_reg <= dec_round_up;
                s1_inexact_reg  <= dec_inexact;
                s1_is_nan_reg   <= in_exp_ones & ~in_man_zero;
                // Signalling NaN: quiet bit (mantissa MSB) clear.
                s1_is_snan_reg  <= in_exp_ones & ~in_man_zero & ~in_man[FP32_MAN_W-1];
                s1_is_inf_reg   <= in_exp_ones & in_man_zero;
                s1_is_zero_reg  <= in_exp_zero & in_man_zero;
                s1_exp_zero_reg <= in_exp_zero;
                s1_tag_reg      <= in_tag;
            end else if (s2_load) begin
                s1_valid_reg <= 1'b0;
            end
        end
    end

    // ---------------- stage 2: pack ----------------
    logic [14:0] mag;
    logic        mag_exp_ones;
    logic [15:0] s2_result_next;
    fflags_t     s2_flags_next;

    // A carry out of the mantissa ripples into the exponent by design.
    assign mag          = s1_kept_reg + 15'(s1_round_up_reg);
    assign mag_exp_ones = &mag[BF16_MAN_W +: BF16_EXP_W];

    always_comb begin
        s2_result_next = {s1_sign_reg, mag};
        s2_flags_next  = '0;
        if (s1_is_nan_reg) begin
            s2_result_next        = BF16_QNAN;
            s2_flags_next.invalid = s1_is_snan_reg;
        end else if (s1_is_inf_reg) begin
            s2_result_next = {s1_sign_reg, BF16_INF};
        end else if (s1_is_zero_reg) begin
            s2_result_next = {s1_sign_reg, 15'd0};
        end else if (mag_exp_ones) begin
            s2_result_next         = {s1_sign_reg, BF16_INF};
            s2_flags_next.overflow = 1'b1;
            s2_flags_next.inexact  = 1'b1;
        end else begin
            s2_flags_next.inexact   = s1_inexact_reg;
            // Tininess judged on the unrounded operand exponent.
            s2_flags_next.underflow = s1_exp_zero_reg & s1_inexact_reg;
        end
    end

    logic [15:0]      s2_result_reg;
    logic [TAG_W-1:0] s2_tag_reg;
    fflags_t          s2_flags_reg;
    logic [3:0]       fflags_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_reg  <= 1'b0;
            s2_result_reg <= '0;
            s2_tag_reg    <= '0;
            s2_flags_reg  <= '0;
        end else begin
            if (s2_load) begin
                s2_valid_reg  <= 1'b1;
                s2_result_reg <= s2_result_next;
                s2_tag_reg    <= s1_tag_reg;
                s2_flags_reg  <= s2_flags_next;
            end else if (out_hs) begin
                s2_valid_reg <= 1'b0;
            end
        end
    end

    // Sticky flags: a clear wipes history but never the result leaving this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            fflags_reg <= '0;
        end else if (out_hs) begin
            fflags_reg <= (fflags_clear ? 4'b0000 : fflags_reg) | s2_flags_reg;
        end else if (fflags_clear) begin
            fflags_reg <= '0;
        end
    end

    assign out_valid = s2_valid_reg;
    assign result    = s2_result_reg;
    assign out_tag   = s2_tag_reg;
    assign invalid   = s2_flags_reg.invalid;
    assign overflow  = s2_flags_reg.overflow;
    assign underflow = s2_flags_reg.underflow;
    assign inexact   = s2_flags_reg.inexact;
    assign fflags    = fflags_reg;

endmodule
